// File: rtl/lbus_dma_ctl.sv
// Local data bus controller for DMA writes into local memory. Counted
// address/data-present timing, a write buffer, and wait-state insertion when full.
module lbus_dma_ctl #(
    parameter int DATA_W    = 16,
    parameter int BUF_DEPTH = 4,
    parameter int APR_DLY   = 3,
    parameter int DAP_DLY   = 2
) (
    input  logic                         sysclk,
    input  logic                         sys_rst_n,
    input  logic                         test,
    input  logic                         bgnt_n,
    input  logic                         cgnt_n,
    input  logic                         gnt_n,
    input  logic                         ebus_n,
    input  logic                         bapr_n,
    input  logic                         bdap_n,
    input  logic                         mwrite_n,
    input  logic [DATA_W-1:0]            bus_data,
    output logic                         ebd_n,
    output logic                         ebadr,
    output logic                         clkbd,
    output logic                         bact_n,
    output logic                         dbapr,
    output logic                         bwait_n,
    output logic                         mem_wr_valid,
    output logic [DATA_W-1:0]            mem_wr_data,
    input  logic                         mem_wr_ready,
    output logic [$clog2(BUF_DEPTH):0]   buf_count,
    output logic                         buf_ovf
);

    localparam int PW  = $clog2(BUF_DEPTH);
    localparam int CW  = PW + 1;
    localparam int DCW = $clog2(DAP_DLY + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, DWAIT, STALL, CLK, HOLD, RHOLD
    } state_e;

    state_e              state_q, state_d;
    logic [APR_DLY-1:0]  apr_pipe_q;
    logic [DCW-1:0]      dap_cnt_q, dap_cnt_d;
    logic                ebd_n_q, ebd_n_d;
    logic                ebadr_q, ebadr_d;
    logic                clkbd_q, clkbd_d;
    logic                bact_n_q, bact_n_d;
    logic                bwait_n_q, bwait_n_d;
    logic [DATA_W-1:0]   mem_q [BUF_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                buf_full, dap_hit, push, pop, push_ok;

    // Address-present delay line; dbapr is the oldest tap.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            apr_pipe_q <= '0;
        end else begin
            apr_pipe_q[0] <= ~bapr_n;
            for (int i = 1; i < APR_DLY; i++) apr_pipe_q[i] <= apr_pipe_q[i-1];
        end
    end

    assign dbapr    = apr_pipe_q[APR_DLY-1];
    assign buf_full = (count_q == CW'(BUF_DEPTH));

    // The data-present count starts in ADDR so the cycle before DWAIT counts.
    always_comb begin
        dap_cnt_d = '0;
        if ((state_q == ADDR || state_q == DWAIT) && !bdap_n)
            dap_cnt_d = (dap_cnt_q == DCW'(DAP_DLY)) ? dap_cnt_q : dap_cnt_q + DCW'(1);
    end

    assign dap_hit = !bdap_n && (dap_cnt_q >= DCW'(DAP_DLY - 1));

    // State and registered outputs.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            dap_cnt_q <= '0;
            ebd_n_q   <= 1'b1;
            ebadr_q   <= 1'b0;
            clkbd_q   <= 1'b0;
            bact_n_q  <= 1'b1;
            bwait_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            dap_cnt_q <= dap_cnt_d;
            ebd_n_q   <= ebd_n_d;
            ebadr_q   <= ebadr_d;
            clkbd_q   <= clkbd_d;
            bact_n_q  <= bact_n_d;
            bwait_n_q <= bwait_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bgnt_n && dbapr) state_d = ADDR;
            ADDR:    state_d = mwrite_n ? RHOLD : DWAIT;
            DWAIT:   if (dap_hit) state_d = buf_full ? STALL : CLK;
            STALL:   if (!buf_full) state_d = CLK;
            CLK:     state_d = HOLD;
            HOLD,
            RHOLD:   if (bdap_n && !dbapr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && bgnt_n) state_d = IDLE;
        if (test) state_d = IDLE;
    end

    // Enables follow the next state so they line up with the state they belong to.
    always_comb begin
        ebadr_d   = (state_d != IDLE);
        bact_n_d  = (state_d == IDLE);
        clkbd_d   = (state_d == CLK);
        bwait_n_d = (state_d != STALL);
        if (test)
            ebd_n_d = 1'b1;
        else if (clkbd_q)
            ebd_n_d = ebd_n_q;
        else
            ebd_n_d = ~(~ebus_n & ((cgnt_n & gnt_n) | ~bgnt_n | ~bact_n_q));
    end

    assign ebd_n   = ebd_n_q;
    assign ebadr   = ebadr_q;
    assign clkbd   = clkbd_q;
    assign bact_n  = bact_n_q;
    assign bwait_n = bwait_n_q;

    // Write buffer. A push from CLK fires even if the grant drops in that cycle.
    assign push    = (state_q == CLK);
    assign pop     = mem_wr_valid && mem_wr_ready;
    assign push_ok = push && (!buf_full || pop);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (push && buf_full && !pop);
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus_data;
    end

    assign mem_wr_valid = (count_q != '0);
    assign mem_wr_data  = mem_q[rd_ptr_q];
    assign buf_count    = count_q;
    assign buf_ovf      = ovf_q;

endmodule

// File: doc/lbus_dma_ctl.md
Name: lbus_dma_ctl

Overview:
Parametrised local data bus controller for bus-master (DMA) access to local memory. It is the clocked successor of the PAL-based local data bus control.
- Replaces gate-delay timing of address-present/data-present with counted sysclk delays.
- Adds a buffered DMA write FIFO that decouples bus data capture from local memory writes.
- Adds bus wait-state generation when the buffer is full.
- Sits between the bus transceivers (648-style latches) and the local memory write port.

Parameters:
DATA_W, 16, bus/local data width.
BUF_DEPTH, 4, DMA write buffer entries (power of 2, >=2).
APR_DLY, 3, sysclk cycles from bapr_n low to dbapr high (>=1).
DAP_DLY, 2, sysclk cycles bdap_n must be low before data is clocked (>=1).

Ports:
sysclk  in  1  system clock.
sys_rst_n  in  1  asynchronous active-low reset.
test  in  1  test mode; forces all bus enables inactive.
bgnt_n  in  1  bus grant to this card.
cgnt_n  in  1  CPU grant.
gnt_n  in  1  any local grant.
ebus_n  in  1  external bus cycle selected.
bapr_n  in  1  bus address present.
bdap_n  in  1  bus data present.
mwrite_n  in  1  memory write cycle (low = write).
bus_data  in  DATA_W  data from bus transceivers.
ebd_n  out  1  enable bus data onto local bus.
ebadr  out  1  enable bus address to local memory.
clkbd  out  1  one-cycle clock-enable pulse to transceiver registers.
bact_n  out  1  bus activity.
dbapr  out  1  delayed address present.
bwait_n  out  1  bus wait request (low = stall master).
mem_wr_valid  out  1  buffered write available.
mem_wr_data  out  DATA_W  head-of-buffer data.
mem_wr_ready  in  1  local memory accepts the write.
buf_count  out  clog2(BUF_DEPTH)+1  buffer occupancy.
buf_ovf  out  1  sticky overflow error.

Behaviour:
- All inputs are synchronous to sysclk. All outputs are registered except mem_wr_data, which is the FIFO head.
- Reset values: ebd_n=1, ebadr=0, clkbd=0, bact_n=1, dbapr=0, bwait_n=1, mem_wr_valid=0, buf_count=0, buf_ovf=0; FSM=IDLE; FIFO pointers=0.
- dbapr: shift-register copy of ~bapr_n. Rises APR_DLY cycles after bapr_n falls; falls APR_DLY cycles after bapr_n rises.
- FSM states and transitions:
  - IDLE: on ~bgnt_n & dbapr -> ADDR.
  - ADDR: ebadr=1, bact_n=0. Write (~mwrite_n) -> DWAIT. Read -> RHOLD.
  - DWAIT: count consecutive cycles with bdap_n low. When the count reaches DAP_DLY: buffer not full -> CLK; full -> STALL. bdap_n high resets the count.
  - STALL: bwait_n=0. Leave when count < BUF_DEPTH -> CLK.
  - CLK: clkbd=1 for exactly one cycle; push bus_data. -> HOLD.
  - HOLD / RHOLD: bact_n=0 until bdap_n high and dbapr low -> IDLE.
- Deassertion on leaving the active states: ebadr clears on return to IDLE. bact_n returns to 1 the cycle IDLE is entered.
- ebd_n next value = ~(~ebus_n & ((cgnt_n & gnt_n) | ~bgnt_n | bact active)).
  - It must not change in the cycle clkbd=1 (hold the previous value).
- Abort: bgnt_n high in any non-IDLE state -> IDLE next cycle, no push.
  - A pending clkbd still fires if the FSM is already in CLK.
- FIFO:
  - Push only from CLK.
  - Pop when mem_wr_valid & mem_wr_ready.
  - mem_wr_valid = (count != 0).
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo BUF_DEPTH.
- buf_ovf: set if a push is attempted at full (guarded by STALL, so it signals a design fault). Cleared only by reset.
- test=1 forces ebd_n=1, ebadr=0, bact_n=1, clkbd=0, bwait_n=1 and FSM->IDLE synchronously. The FIFO keeps draining.
- Async reset mid-transfer: all state is cleared immediately and buffered data is discarded.

Test Plan:
1. Reset, then bgnt_n=0, mwrite_n=0, bapr_n low at t0, bus_data=16'hA5C3, bdap_n low at t0+4 -> dbapr high at t0+3; ebadr high at t0+4; clkbd single pulse at t0+6; mem_wr_valid=1 and mem_wr_data=16'hA5C3 the next cycle.
2. Hold mem_wr_ready=0 and do 5 DMA writes (0x0001..0x0005) with BUF_DEPTH=4 -> buf_count=4; 5th write holds bwait_n=0 with no clkbd. Pulse mem_wr_ready for 1 cycle -> 5th write clocks in, buf_ovf stays 0, drain order is 1..5.
3. DMA read (mwrite_n=1) -> no clkbd and no push; bact_n low until bdap_n high and dbapr low; ebd_n=0 while ebus_n=0.
4. bgnt_n rises during DWAIT -> IDLE next cycle, buf_count unchanged, bact_n=1.
5. test=1 mid-transfer -> all enables inactive next cycle; FIFO still drains with mem_wr_ready=1.
6. Push and pop in the same cycle at count=2 -> count stays 2; wrap-around across 9 writes keeps data order.
